// File: rtl/rr_sel_pkg.sv
// Shared constants and helpers for the round-robin bus selector.
package rr_sel_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Grant index width; a single channel still gets a 1-bit index.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: first set request scanning upward from last+1 with wrap.
// Feeding last=N-1 turns it into a lowest-index-wins priority picker.
module rr_pick #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] idx
);

    always_comb begin
        int   c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            // last is always < N, so one subtraction is enough to wrap
            c = int'(last) + k;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = SELW'(c);
            end
        end
    end

endmodule

// File: rtl/rr_bus_selector.sv
// Registered N-channel bus selector: arbitrates req/data sources into a single
// valid/ready output register, one word per cycle.
module rr_bus_selector
    import rr_sel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = MODE_RR,
    parameter int SELW  = sel_w(N)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data_in,
    output logic [N-1:0]         ack,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [WIDTH-1:0]     data_out,
    output logic [N-1:0]         grant,
    output logic [SELW-1:0]      grant_idx
);

    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [SELW-1:0]   idx_q, idx_d;
    logic [SELW-1:0]   last_q, last_d;

    logic [SELW-1:0]   pick_last;
    logic [N-1:0]      win_oh;
    logic [SELW-1:0]   win_idx;
    logic [WIDTH-1:0]  win_data;
    logic              load;

    assign pick_last = (MODE == MODE_FIXED) ? SELW'(N - 1) : last_q;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req  (req),
        .last (pick_last),
        .gnt  (win_oh),
        .idx  (win_idx)
    );

    // One-hot AND-OR mux keeps the data path independent of the index encoding
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win_oh[i]) win_data = win_data | data_in[i*WIDTH +: WIDTH];
        end
    end

    assign load = (~valid_q | ready_out) & (|req) & ~reset;
    assign ack  = load ? win_oh : '0;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = win_data;
            grant_d = win_oh;
            idx_d   = win_idx;
            last_d  = win_idx;
        end else if (valid_q && ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= SELW'(N - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign grant     = grant_q;
    assign grant_idx = idx_q;

endmodule

// File: tb/tb_rr_bus_selector.sv
// Scoreboard bench: stimulus pushes expected words, per-instance monitors pop on consume.
module tb_rr_bus_selector;
    import rr_sel_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] d;
        int          idx;
    } exp_t;

    exp_t q4[$];
    exp_t qf[$];
    exp_t q3[$];

    // N=4 round-robin
    logic [3:0]   req4, ack4, gnt4;
    logic [127:0] din4;
    logic         rdy4, vld4;
    logic [31:0]  dout4;
    logic [1:0]   gi4;
    // N=4 fixed priority
    logic [3:0]   reqf, ackf, gntf;
    logic [127:0] dinf;
    logic         rdyf, vldf;
    logic [31:0]  doutf;
    logic [1:0]   gif;
    // N=3 round-robin
    logic [2:0]   req3, ack3, gnt3;
    logic [95:0]  din3;
    logic         rdy3, vld3;
    logic [31:0]  dout3;
    logic [1:0]   gi3;

    rr_bus_selector #(.WIDTH(32), .N(4), .MODE(MODE_RR)) u_rr4 (
        .clock(clock), .reset(reset), .req(req4), .data_in(din4), .ack(ack4),
        .valid_out(vld4), .ready_out(rdy4), .data_out(dout4), .grant(gnt4), .grant_idx(gi4));

    rr_bus_selector #(.WIDTH(32), .N(4), .MODE(MODE_FIXED)) u_fix4 (
        .clock(clock), .reset(reset), .req(reqf), .data_in(dinf), .ack(ackf),
        .valid_out(vldf), .ready_out(rdyf), .data_out(doutf), .grant(gntf), .grant_idx(gif));

    rr_bus_selector #(.WIDTH(32), .N(3), .MODE(MODE_RR)) u_rr3 (
        .clock(clock), .reset(reset), .req(req3), .data_in(din3), .ack(ack3),
        .valid_out(vld3), .ready_out(rdy3), .data_out(dout3), .grant(gnt3), .grant_idx(gi3));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic spurious(input string nm, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected word %0h with nothing expected", nm, act);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && vld4 && rdy4) begin
            if (q4.size() == 0) spurious("rr4 out", dout4);
            else begin
                e = q4.pop_front();
                chk("rr4 data", dout4, e.d);
                chk("rr4 idx", gi4, e.idx);
                chk("rr4 grant", gnt4, 64'd1 << e.idx);
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && vldf && rdyf) begin
            if (qf.size() == 0) spurious("fix4 out", doutf);
            else begin
                e = qf.pop_front();
                chk("fix4 data", doutf, e.d);
                chk("fix4 idx", gif, e.idx);
                chk("fix4 grant", gntf, 64'd1 << e.idx);
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && vld3 && rdy3) begin
            if (q3.size() == 0) spurious("rr3 out", dout3);
            else begin
                e = q3.pop_front();
                chk("rr3 data", dout3, e.d);
                chk("rr3 idx", gi3, e.idx);
                chk("rr3 grant", gnt3, 64'd1 << e.idx);
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        q4.delete(); qf.delete(); q3.delete();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        int          rot_idx[5];
        logic [31:0] rot_dat[5];
        logic [3:0]  rot_ack[5];
        logic [2:0]  n3_ack[4];
        int          n3_idx[4];
        logic [31:0] n3_dat[4];
        rot_idx = '{0, 1, 2, 3, 0};
        rot_dat = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h10};
        rot_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n3_ack  = '{3'b001, 3'b010, 3'b100, 3'b001};
        n3_idx  = '{0, 1, 2, 0};
        n3_dat  = '{32'h30, 32'h31, 32'h32, 32'h30};

        reset = 1'b1;
        req4 = '0; din4 = '0; rdy4 = 1'b0;
        reqf = '0; dinf = '0; rdyf = 1'b0;
        req3 = '0; din3 = '0; rdy3 = 1'b0;

        // reset state and idle
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("reset valid", vld4, 0);
        chk("reset data", dout4, 0);
        chk("reset grant", gnt4, 0);
        chk("reset idx", gi4, 0);
        chk("reset valid n3", vld3, 0);
        repeat (5) begin
            @(posedge clock); #3;
            chk("idle ack", ack4, 0);
            chk("idle valid", vld4, 0);
            chk("idle data", dout4, 0);
        end

        // single channel request
        @(posedge clock); #1;
        req4 = 4'b0100; din4[64 +: 32] = 32'hDEADBEEF; rdy4 = 1'b1;
        #2 chk("single ack", ack4, 4'b0100);
        q4.push_back('{32'hDEADBEEF, 2});
        @(posedge clock); #1 req4 = '0;
        @(posedge clock);

        // round-robin rotation from a fresh reset
        do_reset();
        for (int k = 0; k < 4; k++) din4[k*32 +: 32] = 32'h10 + k;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            req4 = 4'b1111; rdy4 = 1'b1;
            #2 chk("rotate ack", ack4, rot_ack[k]);
            q4.push_back('{rot_dat[k], rot_idx[k]});
        end
        @(posedge clock); #1 req4 = '0;
        @(posedge clock);

        // stall: hold 0xA5 for three cycles while channel 0 waits
        @(posedge clock); #1;
        req4 = 4'b0001; din4[31:0] = 32'hA5; rdy4 = 1'b0;
        #2 chk("stall first ack", ack4, 4'b0001);
        q4.push_back('{32'hA5, 0});
        repeat (3) begin
            @(posedge clock); #1;
            din4[31:0] = 32'h5A;
            #2;
            chk("stall ack", ack4, 0);
            chk("stall valid", vld4, 1);
            chk("stall data", dout4, 32'hA5);
        end
        @(posedge clock); #1 rdy4 = 1'b1;
        #2 chk("stall release ack", ack4, 4'b0001);
        q4.push_back('{32'h5A, 0});
        @(posedge clock); #1 req4 = '0;
        @(posedge clock);

        // fixed priority: channel 1 always beats channel 3
        @(posedge clock); #1;
        rdyf = 1'b1; dinf[96 +: 32] = 32'h333;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            reqf = 4'b1010; dinf[32 +: 32] = 32'h200 + k;
            #2 chk("fixed ack", ackf, 4'b0010);
            qf.push_back('{32'h200 + k, 1});
        end
        @(posedge clock); #1 reqf = '0;
        @(posedge clock);

        // N=3 rotation
        do_reset();
        din3 = {32'h32, 32'h31, 32'h30};
        rdy3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            req3 = 3'b111;
            #2 chk("n3 ack", ack3, n3_ack[k]);
            q3.push_back('{n3_dat[k], n3_idx[k]});
        end
        @(posedge clock); #1 req3 = '0;
        @(posedge clock);

        // N=3 reset after the second grant
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            req3 = 3'b111;
            #2 chk("n3 pre-reset ack", ack3, n3_ack[k]);
            q3.push_back('{n3_dat[k], n3_idx[k]});
        end
        @(posedge clock); #1;
        reset = 1'b1;
        q3.delete();
        #1;
        chk("n3 reset valid", vld3, 0);
        chk("n3 reset ack", ack3, 0);
        @(posedge clock); #1 reset = 1'b0;
        #2 chk("n3 post-reset ack", ack3, 3'b001);
        q3.push_back('{32'h30, 0});
        @(posedge clock); #1 req3 = '0;
        repeat (3) @(posedge clock);
        #1;

        chk("rr4 queue drained", q4.size(), 0);
        chk("fix4 queue drained", qf.size(), 0);
        chk("rr3 queue drained", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
